// File: rtl/traffic_light_ctrl_if.sv
// Sensor/lamp bundle between the traffic light controller and its surroundings.
// The master side drives tick and car_side. The slave side, which is the controller, drives the lamps and status.
interface traffic_light_ctrl_if;
    logic       tick;
    logic       car_side;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic [2:0] state_o;
    logic       req_pend;

    modport master (
        output tick, car_side,
        input  main_lamp, side_lamp, state_o, req_pend
    );

    modport slave (
        input  tick, car_side,
        output main_lamp, side_lamp, state_o, req_pend
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Main/side road Moore controller with a tick-driven dwell timer and a latched side request.
// Optional macro TLC_EXTEND_EN: car_side at the end of side green extends it once by SIDE_GREEN_T ticks.
module traffic_light_ctrl #(
    parameter int MAIN_GREEN_T = 8,
    parameter int SIDE_GREEN_T = 4,
    parameter int YELLOW_T     = 2,
    parameter int ALLRED_T     = 1,
    parameter int CNT_W        = 4
) (
    input logic            clk,
    input logic            reset,
    traffic_light_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    if (MAIN_GREEN_T < 1 || SIDE_GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_dur
        $error("traffic_light_ctrl: every dwell parameter must be >= 1");
    end

    localparam logic [CNT_W-1:0] MG_LIM = CNT_W'(MAIN_GREEN_T - 1);
    localparam logic [CNT_W-1:0] SG_LIM = CNT_W'(SIDE_GREEN_T - 1);
    localparam logic [CNT_W-1:0] Y_LIM  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LIM = CNT_W'(ALLRED_T - 1);

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt, lim;
    logic             req, nxt_req, done;
    logic [2:0]       main_r, side_r;
`ifdef TLC_EXTEND_EN
    logic             ext, nxt_ext;
`endif

    // Lamp pattern {main, side}. Illegal codes show red on both roads.
    function automatic logic [5:0] lamps(input state_t s);
        case (s)
            MG:      lamps = {3'b001, 3'b100};
            MY:      lamps = {3'b010, 3'b100};
            SG:      lamps = {3'b100, 3'b001};
            SY:      lamps = {3'b100, 3'b010};
            default: lamps = {3'b100, 3'b100};
        endcase
    endfunction

    always_comb begin
        case (state)
            MG:       lim = MG_LIM;
            SG:       lim = SG_LIM;
            MY, SY:   lim = Y_LIM;
            default:  lim = AR_LIM;
        endcase
        done = bus.tick && (cnt == lim);
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = bus.tick ? cnt + 1'b1 : cnt;
        nxt_req   = req || (bus.car_side && state != SG);
`ifdef TLC_EXTEND_EN
        nxt_ext   = ext;
`endif
        case (state)
            // Min green reached: hold the saturated count until someone is waiting.
            MG: begin
                if (done) begin
                    if (req || bus.car_side) nxt_state = MY;
                    else                     nxt_cnt   = cnt;
                end
            end
            MY:  if (done) nxt_state = AR1;
            AR1: if (done) nxt_state = SG;
            SG: begin
`ifdef TLC_EXTEND_EN
                if (done && bus.car_side && !ext) begin
                    nxt_cnt = '0;
                    nxt_ext = 1'b1;
                end else if (done) begin
                    nxt_state = SY;
                end
`else
                if (done) nxt_state = SY;
`endif
            end
            SY:  if (done) nxt_state = AR2;
            AR2: if (done) nxt_state = MG;
            default: nxt_state = MG;
        endcase
        if (nxt_state != state) nxt_cnt = '0;
        // Entering side green serves the request. This overrides a same-cycle set.
        if (nxt_state == SG && state != SG) begin
            nxt_req = 1'b0;
`ifdef TLC_EXTEND_EN
            nxt_ext = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= MG;
            cnt    <= '0;
            req    <= 1'b0;
            main_r <= 3'b001;
            side_r <= 3'b100;
`ifdef TLC_EXTEND_EN
            ext    <= 1'b0;
`endif
        end else begin
            state            <= nxt_state;
            cnt              <= nxt_cnt;
            req              <= nxt_req;
            {main_r, side_r} <= lamps(nxt_state);
`ifdef TLC_EXTEND_EN
            ext              <= nxt_ext;
`endif
        end
    end

    assign bus.main_lamp = main_r;
    assign bus.side_lamp = side_r;
    assign bus.state_o   = state;
    assign bus.req_pend  = req;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with default parameters.
// A vector table covers the full cycle, and hand-written sequences cover reset, idle, tick gating and requests during side green.
module tb_traffic_light_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    traffic_light_ctrl_if bus();

    traffic_light_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef TLC_EXTEND_EN
    localparam int EXT = 4;
`else
    localparam int EXT = 0;
`endif

    typedef struct {
        logic       tick;
        logic       car;
        logic [2:0] st;
        logic       rq;
    } vec_t;

    vec_t vt [1:20];

    // Expected state after t ticks from reset, with a request pending from the start.
    // The argument e is the extra side-green dwell.
    function automatic logic [2:0] exp_st(input int t, input int e);
        if (t < 8)       return 3'd0;
        if (t < 10)      return 3'd1;
        if (t == 10)     return 3'd2;
        if (t < 15 + e)  return 3'd3;
        if (t < 17 + e)  return 3'd4;
        if (t == 17 + e) return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic [5:0] exp_lamps(input logic [2:0] st);
        case (st)
            3'd0:    return {3'b001, 3'b100};
            3'd1:    return {3'b010, 3'b100};
            3'd3:    return {3'b100, 3'b001};
            3'd4:    return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] st, input logic rq);
        logic [5:0] l;
        l = exp_lamps(st);
        total++;
        if (bus.state_o !== st) begin
            bad++;
            $display("FAIL %s[%0d] state_o got %0d want %0d", name, idx, bus.state_o, st);
        end
        total++;
        if (bus.main_lamp !== l[5:3]) begin
            bad++;
            $display("FAIL %s[%0d] main_lamp got %b want %b", name, idx, bus.main_lamp, l[5:3]);
        end
        total++;
        if (bus.side_lamp !== l[2:0]) begin
            bad++;
            $display("FAIL %s[%0d] side_lamp got %b want %b", name, idx, bus.side_lamp, l[2:0]);
        end
        total++;
        if (bus.req_pend !== rq) begin
            bad++;
            $display("FAIL %s[%0d] req_pend got %b want %b", name, idx, bus.req_pend, rq);
        end
    endtask

    task automatic step(input logic t, input logic c);
        bus.tick     = t;
        bus.car_side = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b1, 1'b1);
        check("rst_pulse", 0, 3'd0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 1; i <= 20; i++)
            vt[i] = '{1'b1, (i == 2), exp_st(i, 0), (i >= 2 && i <= 10)};

        // Reset dominates tick and car_side.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("reset", i, 3'd0, 1'b0);
        end
        reset = 1'b1;

        // Full cycle from a one-cycle car pulse.
        for (int i = 1; i <= 20; i++) begin
            step(vt[i].tick, vt[i].car);
            check("full", i, vt[i].st, vt[i].rq);
        end

        // No request: main green holds with a saturated counter.
        for (int i = 1; i <= 50; i++) begin
            step(1'b1, 1'b0);
            check("idle", i, 3'd0, 1'b0);
        end

        // Tick every 4th cycle, with the request latched on a non-tick cycle.
        do_reset();
        for (int c = 1; c <= 76; c++) begin
            step((c % 4) == 0, (c == 1));
            check("gate", c, exp_st(c / 4, 0), (c < 44));
        end

        // car_side held through side green: no latch while in SG, latch in SY, then a second cycle.
        do_reset();
        for (int i = 1; i <= 26 + EXT; i++) begin
            step(1'b1, (i <= 16 + EXT));
            check("sgreq", i, (i >= 26 + EXT) ? 3'd1 : exp_st(i, EXT),
                  (i <= 10) || (i >= 16 + EXT));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
